// File: rtl/serial_add_pkg.sv
// Shared types and helpers for the bit-serial adder controller.
package serial_add_pkg;

  // Controller state encoding.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bit-counter width for a given operand width; never narrower than one bit.
  function automatic int cnt_width(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/fullAdder.sv
// One-bit full-adder cell shared across the serial arithmetic blocks.
module fullAdder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: adds two WIDTH-bit operands LSB first using a
// single full-adder cell, one bit per clock.
// Optional macro SERIAL_ADD_SUB_EN adds a 'sub' port selecting a-b.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_t state_reg, state_next;

  logic [WIDTH-1:0] opa_reg;
  logic [WIDTH-1:0] opb_reg;
  logic [WIDTH-1:0] psum_reg;
  logic [WIDTH-1:0] psum_next;
  logic [WIDTH-1:0] sum_reg;
  logic [CW-1:0]    cnt_reg;
  logic             carry_reg;
  logic             cout_reg;
  logic             last_bit;

  logic fa_b;
  logic fa_s;
  logic fa_cout;
  logic carry_init;

`ifdef SERIAL_ADD_SUB_EN
  logic sub_reg;

  // Subtraction is a + ~b + 1: invert B at the cell and seed the carry with 1.
  always_ff @(posedge clk) begin
    if (reset) begin
      sub_reg <= 1'b0;
    end else if (state_reg == IDLE && start) begin
      sub_reg <= sub;
    end
  end

  assign fa_b       = opb_reg[0] ^ sub_reg;
  assign carry_init = sub;
`else
  assign fa_b       = opb_reg[0];
  assign carry_init = 1'b0;
`endif

  fullAdder u_fa (
    .a    (opa_reg[0]),
    .b    (fa_b),
    .cin  (carry_reg),
    .s    (fa_s),
    .cout (fa_cout)
  );

  assign psum_next = {fa_s, psum_reg[WIDTH-1:1]};
  assign last_bit  = (cnt_reg == LAST_BIT);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state and handshake decode; start is only honoured in IDLE.
  always_comb begin
    state_next = state_reg;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (last_bit) begin
          state_next = DONE;
        end
      end
      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Operand/partial-sum shifting, carry and bit counter; the visible result
  // is only written on the final bit so partial sums never leak out.
  always_ff @(posedge clk) begin
    if (reset) begin
      opa_reg   <= '0;
      opb_reg   <= '0;
      psum_reg  <= '0;
      sum_reg   <= '0;
      cnt_reg   <= '0;
      carry_reg <= 1'b0;
      cout_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            opa_reg   <= a;
            opb_reg   <= b;
            psum_reg  <= '0;
            cnt_reg   <= '0;
            carry_reg <= carry_init;
          end
        end
        RUN: begin
          opa_reg   <= opa_reg >> 1;
          opb_reg   <= opb_reg >> 1;
          psum_reg  <= psum_next;
          carry_reg <= fa_cout;
          cnt_reg   <= cnt_reg + CW'(1);
          if (last_bit) begin
            sum_reg  <= psum_next;
            cout_reg <= fa_cout;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign sum  = sum_reg;
  assign cout = cout_reg;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed testbench for serial_add_ctrl (WIDTH=8) with a result scoreboard.
module tb_serial_add_ctrl;

  localparam int W = 8;

  typedef struct packed {
    logic [W-1:0] s;
    logic         c;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         sub_i = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   done_cnt = 0;
  int   last_done_cyc = 0;
  int   acc_cyc = 0;
  exp_t sb[$];

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .a     (a),
    .b     (b),
`ifdef SERIAL_ADD_SUB_EN
    .sub   (sub_i),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer: every done pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (done) begin
      done_cnt++;
      last_done_cyc = cyc;
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sum", 32'(sum), 32'(e.s));
        chk("cout", 32'(cout), 32'(e.c));
        $display("done: sum=%0d cout=%0d expected sum=%0d cout=%0d", sum, cout, e.s, e.c);
      end
    end
  end

  task automatic smp();
    @(negedge clk);
    #1;
  endtask

  function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv, input logic sv);
    logic [W:0] r;
    exp_t e;
    if (sv) r = {1'b0, av} + {1'b0, ~bv} + (W+1)'(1);
    else    r = {1'b0, av} + {1'b0, bv};
    e.s = r[W-1:0];
    e.c = r[W];
    return e;
  endfunction

  // Drive one start pulse; the DUT must be in IDLE at the following edge.
  task automatic accept(input logic [W-1:0] av, input logic [W-1:0] bv, input logic sv, input bit push);
    @(posedge clk);
    #1;
    a = av; b = bv; sub_i = sv; start = 1'b1;
    if (push) sb.push_back(model(av, bv, sv));
    @(posedge clk);
    #1;
    start = 1'b0;
    a = $urandom; b = $urandom; sub_i = 1'b0;
    acc_cyc = cyc;
    $display("start: a=%0d b=%0d sub=%0d", av, bv, sv);
  endtask

  // Wait for the operation to complete, checking latency and busy length.
  task automatic finish_op(input string tag);
    int n = 0;
    int busy_n = 0;
    int d0 = done_cnt;
    while (n < 40 && !(done_cnt > d0 && !busy)) begin
      smp();
      if (busy) busy_n++;
      n++;
    end
    chk({tag, "_done_seen"}, 32'(done_cnt - d0), 32'd1);
    chk({tag, "_latency"}, 32'(last_done_cyc - acc_cyc), 32'(W));
    chk({tag, "_busy_len"}, 32'(busy_n), 32'(W + 1));
  endtask

  initial begin
    int d0;
    int t1;
    int n;
    bit stable;

    // Reset state.
    repeat (2) @(posedge clk);
    smp();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Basic addition and carry chain.
    accept(8'd23, 8'd42, 1'b0, 1'b1);
    finish_op("add23_42");
    accept(8'd255, 8'd1, 1'b0, 1'b1);
    finish_op("add255_1");
    accept(8'd200, 8'd100, 1'b0, 1'b1);
    finish_op("add200_100");

    // start while busy is ignored.
    d0 = done_cnt;
    accept(8'd10, 8'd5, 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    a = 8'd99; b = 8'd99; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    start = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    start = 1'b0;
    repeat (15) smp();
    chk("busy_ign_done_cnt", 32'(done_cnt - d0), 32'd1);
    chk("busy_ign_hold_sum", 32'(sum), 32'd15);
    chk("busy_ign_idle", 32'(busy), 32'd0);
    chk("busy_ign_sb_empty", 32'(sb.size()), 32'd0);

    // Reset mid-operation.
    d0 = done_cnt;
    accept(8'd100, 8'd100, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    smp();
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_sum", 32'(sum), 32'd0);
    chk("midrst_cout", 32'(cout), 32'd0);
    repeat (12) smp();
    chk("midrst_no_done", 32'(done_cnt - d0), 32'd0);
    accept(8'd1, 8'd2, 1'b0, 1'b1);
    finish_op("add1_2");

    // reset and start together: reset wins.
    @(posedge clk);
    #1;
    reset = 1'b1; start = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0; start = 1'b0;
    smp();
    chk("rst_start_busy", 32'(busy), 32'd0);
    repeat (12) smp();
    chk("rst_start_sb", 32'(sb.size()), 32'd0);

    // Back-to-back with start held high.
    d0 = done_cnt;
    sb.push_back(model(8'd7, 8'd8, 1'b0));
    sb.push_back(model(8'd250, 8'd10, 1'b0));
    @(posedge clk);
    #1;
    a = 8'd7; b = 8'd8; start = 1'b1;
    @(posedge clk);
    #1;
    a = 8'd250; b = 8'd10;
    repeat (10) @(posedge clk);
    #1;
    start = 1'b0;
    n = 0;
    while (n < 30 && done_cnt < d0 + 1) begin smp(); n++; end
    t1 = last_done_cyc;
    stable = 1'b1;
    for (int i = 0; i < 8; i++) begin
      smp();
      if (done_cnt < d0 + 2 && sum !== 8'd15) stable = 1'b0;
    end
    chk("b2b_sum_stable", 32'(stable), 32'd1);
    n = 0;
    while (n < 30 && done_cnt < d0 + 2) begin smp(); n++; end
    chk("b2b_done_cnt", 32'(done_cnt - d0), 32'd2);
    chk("b2b_spacing", 32'(last_done_cyc - t1), 32'(W + 2));
    repeat (15) smp();
    chk("b2b_no_third", 32'(done_cnt - d0), 32'd2);

`ifdef SERIAL_ADD_SUB_EN
    accept(8'd50, 8'd20, 1'b1, 1'b1);
    finish_op("sub50_20");
    accept(8'd20, 8'd50, 1'b1, 1'b1);
    finish_op("sub20_50");
`endif

    repeat (3) smp();
    chk("final_sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
- Bit-serial adder controller. Reuses a single one-bit full-adder cell (the team's existing fullAdder module) over WIDTH clock cycles to add two WIDTH-bit operands, LSB first.
- Used wherever area matters more than latency, e.g. score/position accumulation in the game logic.
- Owns sequencing, the carry register, the operand and sum shift registers, and the start/done handshake.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 2..32.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request a new addition; sampled only in IDLE.
- a  input  WIDTH  operand A; latched on the accepted start edge.
- b  input  WIDTH  operand B; latched on the accepted start edge.
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle pulse when result and cout are valid.
- sum  output  WIDTH  registered result; held until the next result is written.
- cout  output  1  registered final carry (unsigned overflow).

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values: state=IDLE, busy=0, done=0, sum=0, cout=0, internal shift registers=0, carry=0, bit counter=0.
- States: IDLE, RUN, DONE.
- IDLE:
  - busy=0, done=0.
  - On an edge with start=1: latch a and b into shift registers, clear carry, set counter=0, go to RUN.
  - start=0: stay in IDLE.
- RUN:
  - busy=1.
  - Full-adder inputs: A=opA[0], B=opB[0], Cin=carry.
  - Each edge: shift opA and opB right by 1; shift the partial-sum register right, inserting the full-adder sum at bit WIDTH-1; carry <= full-adder Cout; counter++.
  - On the edge where counter==WIDTH-1, copy the completed partial sum into sum, copy Cout into cout, and go to DONE.
- DONE: busy=1, done=1 for exactly one cycle, then unconditionally return to IDLE.
- Latency:
  - start is accepted at edge 0.
  - Bits are processed on edges 1..WIDTH.
  - done is high during the cycle following edge WIDTH.
  - Minimum start-to-start spacing is WIDTH+2 cycles.
- Handshake:
  - start is ignored in RUN and in DONE; no queuing.
  - start held high continuously produces back-to-back operations, each separated by one IDLE cycle.
- Output stability:
  - sum and cout change only on the edge that enters DONE (or on reset).
  - They stay stable through IDLE and during the next operation's RUN.
- Arithmetic: unsigned; sum = (a+b) mod 2^WIDTH; cout = bit WIDTH of a+b.
- Input stability: operands are sampled once; a and b may change freely after the accept edge.
- Reset mid-operation: on the next edge, return to IDLE with all reset values. sum and cout clear to 0, no done pulse, and no partial result is exposed.
- reset and start high together: reset wins; the start is not accepted.

Optional Feature:
- Macro: SERIAL_ADD_SUB_EN.
- Defined:
  - Adds input port sub (1 bit), latched with the operands on the accept edge.
  - When sub=1: the B operand is inverted before the full adder, and carry initialises to 1, computing a-b mod 2^WIDTH.
  - cout=1 means no borrow (a>=b).
  - Timing and handshake are unchanged.
- Undefined: no sub port; addition only; logic identical to the base behaviour.

Decomposition:
- Shared package serial_add_pkg:
  - state enum type (IDLE, RUN, DONE), 2-bit encoding.
  - localparam function for the counter width, $clog2(WIDTH).
- Datapath cell: one instance of the existing one-bit full-adder module; no new sub-module.
- FSM, counter and shift registers live in serial_add_ctrl itself.

Test Plan:
- Default run, WIDTH=8: reset 2 cycles; a=23, b=42, start pulse -> done pulses exactly 8 cycles after the accept edge; sum=65, cout=0; busy high for 9 cycles.
- Carry chain and overflow: a=255, b=1 -> sum=0, cout=1. Then a=200, b=100 -> sum=44, cout=1.
- start while busy: accept a=10, b=5; pulse start with a=99, b=99 at RUN cycles 3 and 8 and in DONE -> single result sum=15; no second done; sum holds 15 in IDLE.
- Reset mid-operation: accept a=100, b=100; assert reset at RUN cycle 4 -> next cycle busy=0, sum=0, cout=0, and no done. A fresh start with a=1, b=2 then yields sum=3.
- Back-to-back: start held high; a=7, b=8 then a=250, b=10 -> done pulses 10 cycles apart; results 15/0 and 4/1; sum stays stable between the pulses.
- SERIAL_ADD_SUB_EN defined: a=50, b=20, sub=1 -> sum=30, cout=1. Then a=20, b=50, sub=1 -> sum=226, cout=0.
